// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: CPU load/store path vs. debug/loader requester.
// Optional round-robin for unlocked contention via DMEM_ARB_RR_EN.
module dmem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_op,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [2:0]        dbg_op,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              m_re,
  output logic              m_we,
  output logic [2:0]        m_op,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  logic              rd_pend;
  logic              rd_owner;
  logic [LW-1:0]     lock_cnt;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] dbg_hold;

  logic cpu_req, cpu_ret, dbg_ret;
  logic cpu_elig, dbg_elig;
  logic lock_ok, rr_dbg;
  logic cpu_win, dbg_win;

  assign cpu_req  = cpu_re | cpu_we;
  assign cpu_ret  = rd_pend & (rd_owner == OWN_CPU);
  assign dbg_ret  = rd_pend & (rd_owner == OWN_DBG);
  // Outputs are forced quiet while reset is held, even with live requests.
  assign cpu_elig = rst & cpu_req & ~cpu_ret;
  assign dbg_elig = rst & dbg_req;
  assign lock_ok  = dbg_lock & (lock_cnt < LW'(MAX_LOCK));

`ifdef DMEM_ARB_RR_EN
  logic last_gnt;
  assign rr_dbg = (last_gnt == OWN_CPU);
`else
  assign rr_dbg = 1'b0;
`endif

  assign dbg_win = dbg_elig & (~cpu_elig | lock_ok | rr_dbg);
  assign cpu_win = cpu_elig & ~dbg_win;

  assign dbg_gnt = dbg_win;
  assign m_re    = (cpu_win & cpu_re) | (dbg_win & ~dbg_we);
  assign m_we    = (cpu_win & cpu_we) | (dbg_win & dbg_we);
  assign m_op    = dbg_win ? dbg_op : cpu_op;
  assign m_addr  = dbg_win ? dbg_addr : cpu_addr;
  assign m_wdata = dbg_win ? dbg_wdata : cpu_wdata;

  assign cpu_stall  = rst & cpu_req & ~cpu_ret & ~(cpu_win & cpu_we);
  assign cpu_rdata  = cpu_ret ? m_rdata : cpu_hold;
  assign dbg_rvalid = dbg_ret;
  assign dbg_rdata  = dbg_ret ? m_rdata : dbg_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= OWN_CPU;
      lock_cnt <= '0;
      cpu_hold <= '0;
      dbg_hold <= '0;
    end else begin
      rd_pend  <= (cpu_win & cpu_re) | (dbg_win & ~dbg_we);
      rd_owner <= dbg_win ? OWN_DBG : OWN_CPU;
      if (cpu_ret) cpu_hold <= m_rdata;
      if (dbg_ret) dbg_hold <= m_rdata;
      if (cpu_win || !dbg_lock)
        lock_cnt <= '0;
      else if (dbg_win && cpu_elig && lock_cnt < LW'(MAX_LOCK))
        lock_cnt <= lock_cnt + 1'b1;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      last_gnt <= OWN_DBG;
    else if (cpu_win)
      last_gnt <= OWN_CPU;
    else if (dbg_win)
      last_gnt <= OWN_DBG;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural sync-read memory.
// Expectations for unlocked contention follow DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [2:0]  cpu_op;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [2:0]  dbg_op;
  logic [8:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        m_re, m_we;
  logic [2:0]  m_op;
  logic [8:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;

  logic [31:0] mem [0:511];
  int tests;
  int fails;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_op(cpu_op),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
    .dbg_op(dbg_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .m_re(m_re), .m_we(m_we), .m_op(m_op), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_wdata;
    if (m_re) m_rdata <= mem[m_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    cpu_re = 0; cpu_we = 0; cpu_op = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_op = 0;
    dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_m_re"}, m_re, 0);
    chk({tag, "_m_we"}, m_we, 0);
    chk({tag, "_dbg_gnt"}, dbg_gnt, 0);
    chk({tag, "_dbg_rvalid"}, dbg_rvalid, 0);
    chk({tag, "_cpu_stall"}, cpu_stall, 0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 0);
    chk({tag, "_dbg_rdata"}, dbg_rdata, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m_rdata = '0;
    for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
    mem[9'h010] <= 32'hDEADBEEF;
    mem[9'h020] <= 32'hA5A50001;
    mem[9'h030] <= 32'h0BADF00D;
    idle();
    rst = 0;
    // Live requests during reset must stay invisible
    cpu_re = 1; dbg_req = 1;
    repeat (2) @(negedge clk);
    #1 reset_vals("rst");
    @(negedge clk);
    idle();
    rst = 1;

    // Uncontended CPU load: one stall cycle
    @(negedge clk);
    cpu_re = 1; cpu_addr = 9'h010; cpu_op = 3'b010;
    #1;
    chk("ld_m_re", m_re, 1);
    chk("ld_m_addr", m_addr, 9'h010);
    chk("ld_m_op", m_op, 3'b010);
    chk("ld_stall0", cpu_stall, 1);
    @(negedge clk);
    #1;
    chk("ld_stall1", cpu_stall, 0);
    chk("ld_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("ld_m_re1", m_re, 0);

    // CPU store retires in grant cycle; read back via DBG
    @(negedge clk);
    idle();
    cpu_we = 1; cpu_addr = 9'h004; cpu_wdata = 32'h12345678;
    #1;
    chk("st_m_we", m_we, 1);
    chk("st_stall", cpu_stall, 0);
    chk("st_rdata_hold", cpu_rdata, 32'hDEADBEEF);
    @(negedge clk);
    idle();
    dbg_req = 1; dbg_addr = 9'h004;
    #1;
    chk("drd_gnt", dbg_gnt, 1);
    chk("drd_m_re", m_re, 1);
    @(negedge clk);
    idle();
    #1;
    chk("drd_rvalid", dbg_rvalid, 1);
    chk("drd_rdata", dbg_rdata, 32'h12345678);
    @(negedge clk);
    #1;
    chk("drd_rvalid0", dbg_rvalid, 0);
    chk("drd_hold", dbg_rdata, 32'h12345678);

    // Contention after a DBG grant: CPU first, DBG in CPU return cycle
    @(negedge clk);
    cpu_re = 1; cpu_addr = 9'h020;
    dbg_req = 1; dbg_addr = 9'h030;
    #1;
    chk("ct_gnt0", dbg_gnt, 0);
    chk("ct_stall0", cpu_stall, 1);
    chk("ct_addr0", m_addr, 9'h020);
    @(negedge clk);
    #1;
    chk("ct_gnt1", dbg_gnt, 1);
    chk("ct_addr1", m_addr, 9'h030);
    chk("ct_cpu_rdata", cpu_rdata, 32'hA5A50001);
    chk("ct_stall1", cpu_stall, 0);
    @(negedge clk);
    idle();
    #1;
    chk("ct_rvalid", dbg_rvalid, 1);
    chk("ct_dbg_rdata", dbg_rdata, 32'h0BADF00D);
    chk("ct_cpu_keep", cpu_rdata, 32'hA5A50001);

    // Unlocked contention right after a CPU grant
    @(negedge clk);
    cpu_we = 1; cpu_addr = 9'h008; cpu_wdata = 32'h11112222;
    @(negedge clk);
    cpu_addr = 9'h009; cpu_wdata = 32'h33334444;
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h00A; dbg_wdata = 32'h55556666;
    #1;
`ifdef DMEM_ARB_RR_EN
    chk("rr_dbg_gnt", dbg_gnt, 1);
    chk("rr_stall", cpu_stall, 1);
    chk("rr_addr", m_addr, 9'h00A);
`else
    chk("pri_dbg_gnt", dbg_gnt, 0);
    chk("pri_stall", cpu_stall, 0);
    chk("pri_addr", m_addr, 9'h009);
`endif
    @(negedge clk);
    idle();
    #1;
    chk("ct2_idle_we", m_we, 0);

    // Locked DBG write burst against a waiting CPU load
    @(negedge clk);
    cpu_re = 1; cpu_addr = 9'h010;
    dbg_req = 1; dbg_we = 1; dbg_lock = 1;
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 9'h040 + 9'(i);
      dbg_wdata = 32'(i);
      #1;
      chk($sformatf("lk_gnt%0d", i), dbg_gnt, 1);
      chk($sformatf("lk_addr%0d", i), m_addr, 9'h040 + 9'(i));
      chk($sformatf("lk_stall%0d", i), cpu_stall, 1);
      @(negedge clk);
    end
    dbg_addr = 9'h048; dbg_wdata = 32'h8;
    #1;
    chk("lk_cpu_gnt", dbg_gnt, 0);
    chk("lk_cpu_m_re", m_re, 1);
    chk("lk_cpu_addr", m_addr, 9'h010);
    @(negedge clk);
    #1;
    chk("lk_ret_stall", cpu_stall, 0);
    chk("lk_ret_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("lk_ret_dbg", dbg_gnt, 1);
    @(negedge clk);
    cpu_addr = 9'h020; dbg_addr = 9'h049;
    #1;
    chk("lk_cnt_clr", dbg_gnt, 1);
    chk("lk_cnt_stall", cpu_stall, 1);
    @(negedge clk);
    idle();
    dbg_req = 1; dbg_addr = 9'h043;
    @(negedge clk);
    idle();
    #1;
    chk("lk_mem", dbg_rdata, 32'h3);

    // Reset during a DBG read issue cycle
    @(negedge clk);
    dbg_req = 1; dbg_addr = 9'h010;
    #1 chk("mr_gnt", dbg_gnt, 1);
    #1 rst = 0;
    @(negedge clk);
    #1 reset_vals("mr");
    @(negedge clk);
    idle();
    rst = 1;
    @(negedge clk);
    #1;
    chk("mr_rvalid", dbg_rvalid, 0);
    chk("mr_dbg_rdata", dbg_rdata, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter sharing the single data-memory port between the CPU load/store path and a debug/loader requester. Sits between the CPU's `memread`/`memwrite`/`memop`/`memaddr`/`memdatain` outputs and a synchronous-read data memory. Issues at most one memory command per cycle, returns read data to the owning port one cycle later, and stalls the CPU while its access is pending or lost arbitration. Supports bounded debug bus locking for burst loads.

## Interface
- `ADDR_W`, 9, memory word-address width
- `DATA_W`, 32, data width
- `MAX_LOCK`, 8, max consecutive debug grants under `dbg_lock` while the CPU waits (≥1)

- `clk` in 1 — sole clock, rising edge
- `rst` in 1 — reset, asynchronous, active-low
- `cpu_re`, `cpu_we` in 1 — CPU read/write request (mutually exclusive)
- `cpu_op` in 3 — CPU access size/sign code, passed through
- `cpu_addr` in ADDR_W; `cpu_wdata` in DATA_W
- `cpu_rdata` out DATA_W — load data, valid when `cpu_stall`=0 on a read
- `cpu_stall` out 1 — hold PC/regfile this cycle
- `dbg_req`, `dbg_we`, `dbg_lock` in 1; `dbg_op` in 3; `dbg_addr` in ADDR_W; `dbg_wdata` in DATA_W
- `dbg_gnt` out 1 — command accepted this cycle (combinational)
- `dbg_rvalid` out 1; `dbg_rdata` out DATA_W
- `m_re`, `m_we` out 1; `m_op` out 3; `m_addr` out ADDR_W; `m_wdata` out DATA_W
- `m_rdata` in DATA_W — valid the cycle after `m_re`

## Operation
- Registered state: `rd_pend` (0/1), `rd_owner` (CPU/DBG), `last_gnt` (CPU/DBG), `lock_cnt` (0..MAX_LOCK).
- Eligibility: CPU eligible when (`cpu_re`|`cpu_we`) and not (`rd_pend` & `rd_owner`=CPU). DBG eligible when `dbg_req`.
- Grant (combinational, one winner): single eligible requester wins. Both eligible: DBG wins if `dbg_lock`=1 and `lock_cnt`<MAX_LOCK; otherwise per Configuration.
- Winner's command drives `m_*`; loser's is ignored (requester holds it). No winner: `m_re`=`m_we`=0, other `m_*` don't-care.
- CPU write granted: `cpu_stall`=0 (retires). CPU read granted: `cpu_stall`=1; next cycle `rd_pend`=1/owner CPU, `cpu_rdata`=`m_rdata`, `cpu_stall`=0, CPU not re-eligible that cycle (same instruction still presented). CPU requesting but not granted: `cpu_stall`=1. No CPU request: `cpu_stall`=0.
- DBG read granted: next cycle `dbg_rvalid`=1, `dbg_rdata`=`m_rdata`. DBG write commits at the granting edge.
- A new command may be issued in the same cycle as a read-data return (one-deep pipeline).
- `lock_cnt`: +1 (saturating at MAX_LOCK) on each DBG grant while CPU eligible and `dbg_lock`=1; cleared on CPU grant or when `dbg_lock`=0.
- `last_gnt` updates to the winner on every grant.

## Timing
- Reset (`rst`=0, asynchronous): `rd_pend`=0, `lock_cnt`=0, `last_gnt`=DBG; outputs `m_re`=`m_we`=0, `dbg_gnt`=0, `dbg_rvalid`=0, `cpu_stall`=0, `cpu_rdata`=`dbg_rdata`=0.
- Reset mid-read: pending return discarded; no `dbg_rvalid`, CPU re-issues after release.
- Grant latency 0 cycles; read latency 1 cycle after grant; write latency 0 (commit at grant edge).
- Uncontended CPU load: exactly 1 stall cycle. CPU store: 0 stall cycles.
- `cpu_rdata`/`dbg_rdata` hold last returned value when no return.

## Configuration
- `DMEM_ARB_RR_EN` defined: unlocked contention goes to the requester ≠ `last_gnt` (round robin; CPU wins first contention after reset).
- Undefined: unlocked contention always goes to CPU; `last_gnt` unused; lock bound still applies.

## Test plan
- Reset, CPU `cpu_re` addr 0x010 alone, memory word 0xDEADBEEF -> `m_re`=1 cycle 0 with `cpu_stall`=1; cycle 1 `cpu_stall`=0, `cpu_rdata`=0xDEADBEEF, `m_re`=0.
- CPU `cpu_we` addr 0x004 data 0x12345678 alone -> `m_we`=1, `cpu_stall`=0 same cycle; later DBG read of 0x004 -> `dbg_rvalid`=1, `dbg_rdata`=0x12345678.
- RR on: CPU and DBG read continuously -> grants alternate CPU,DBG,CPU,...; RR off -> DBG granted only in CPU's return cycles.
- DBG `dbg_lock`=1 write burst with CPU load pending, MAX_LOCK=8 -> exactly 8 DBG grants, then CPU granted, `lock_cnt` back to 0.
- CPU read return cycle with DBG read pending -> DBG granted same cycle as `cpu_rdata` return; `dbg_rvalid` next cycle, no data swap.
- `rst` pulled low during DBG read's issue cycle -> no `dbg_rvalid` after release; all outputs at reset values.
